// File: rtl/uart_dump_pkg.sv
// uart_dump_pkg
//   Shared types and defaults for the UART dump sequencer.
//   - dump_state_t : frame-level states (header, length, payload read/send, checksum, finish)
//   - hs_state_t   : per-byte transmitter handshake states
//   - HDR_BYTE_DEFAULT / START_HOLD_DEFAULT : default header value and trans_en hold length
//   - is_byte_state(): true for the states that push one byte onto the line
package uart_dump_pkg;

  localparam logic [7:0]  HDR_BYTE_DEFAULT   = 8'hA5;
  localparam int unsigned START_HOLD_DEFAULT = 10416;

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    LEN_HI,
    LEN_LO,
    RD,
    RDW,
    PAY,
    CSUM,
    FIN
  } dump_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN
  } hs_state_t;

  function automatic logic is_byte_state(input dump_state_t s);
    return (s == HDR) || (s == LEN_HI) || (s == LEN_LO) || (s == PAY) || (s == CSUM);
  endfunction

endpackage

// File: rtl/uart_dump_sequencer_if.sv
// uart_dump_sequencer_if
//   Bundles the control, sample-RAM read port and UART transmitter signals of the
//   dump sequencer.
//   master : the sequencer (drives mem_rd_en, mem_addr, trans_en, data_out, active, done)
//   slave  : the surroundings (drives start, byte_count, abort, mem_rd_data, tx_busy)
interface uart_dump_sequencer_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] byte_count;
  logic              abort;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic              trans_en;
  logic [7:0]        data_out;
  logic              tx_busy;
  logic              active;
  logic              done;

  modport master (
    input  start, byte_count, abort, mem_rd_data, tx_busy,
    output mem_rd_en, mem_addr, trans_en, data_out, active, done
  );

  modport slave (
    output start, byte_count, abort, mem_rd_data, tx_busy,
    input  mem_rd_en, mem_addr, trans_en, data_out, active, done
  );
endinterface

// File: rtl/uart_byte_handshake.sv
// uart_byte_handshake
//   Hands one byte to the UART transmitter without loss or repetition.
//   go pulses start a handshake: trans_en is raised until tx_busy is seen, then held
//   for START_HOLD more cycles so the transmitter's baud edge is guaranteed to see it,
//   then dropped while waiting for tx_busy to fall. byte_done pulses on that fall.
//   Ports: input_clk, reset (async, active-low), go, tx_busy -> trans_en, byte_done
module uart_byte_handshake
  import uart_dump_pkg::*;
#(
  parameter int unsigned START_HOLD = START_HOLD_DEFAULT
) (
  input  logic input_clk,
  input  logic reset,
  input  logic go,
  input  logic tx_busy,
  output logic trans_en,
  output logic byte_done
);

  localparam int unsigned      CNT_W     = $clog2(START_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(START_HOLD - 1);

  hs_state_t        state_reg, state_next;
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;

  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    trans_en      = 1'b0;
    byte_done     = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (go) state_next = S_REQ;
      end
      S_REQ: begin
        trans_en = 1'b1;
        // A transmitter that is already busy lets us through at once; the hold
        // below still keeps trans_en up across at least one baud edge.
        if (tx_busy) begin
          state_next    = S_HOLD;
          hold_cnt_next = '0;
        end
      end
      S_HOLD: begin
        trans_en = 1'b1;
        if (hold_cnt_reg == HOLD_LAST) begin
          state_next    = S_DRAIN;
          hold_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        // trans_en stays low here so the finishing transmitter cannot resend.
        if (!tx_busy) begin
          byte_done  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_dump_sequencer.sv
// uart_dump_sequencer
//   Streams one captured sample buffer to the host through the UART transmitter.
//   Frame: HDR_BYTE, length hi, length lo, N payload bytes from sample RAM, checksum.
//   The checksum is the 8-bit sum of the two length bytes and the payload bytes sent.
//   Ports: input_clk, reset (async, active-low), bus (master side of
//   uart_dump_sequencer_if: start/byte_count/abort control, RAM read port,
//   trans_en/data_out/tx_busy transmitter link, active/done status).
module uart_dump_sequencer
  import uart_dump_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned START_HOLD = START_HOLD_DEFAULT,
  parameter logic [7:0]  HDR_BYTE   = HDR_BYTE_DEFAULT
) (
  input  logic                 input_clk,
  input  logic                 reset,
  uart_dump_sequencer_if.master bus
);

  dump_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] n_reg, n_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        csum_reg, csum_next;
  logic [7:0]        data_reg, data_next;
  logic              go_reg, go_next;
  logic              byte_done;
  logic              hs_trans_en;
  logic [15:0]       len16;
  logic [ADDR_W:0]   addr_inc;
  logic              more;

  // Length field is always 16 bits on the line; narrower counts are zero-extended.
  assign len16    = 16'(n_reg);
  // One extra bit so the last address compare cannot wrap.
  assign addr_inc = {1'b0, addr_reg} + (ADDR_W + 1)'(1);
  assign more     = addr_inc < {1'b0, n_reg};

  uart_byte_handshake #(
    .START_HOLD (START_HOLD)
  ) u_hs (
    .input_clk (input_clk),
    .reset     (reset),
    .go        (go_reg),
    .tx_busy   (bus.tx_busy),
    .trans_en  (hs_trans_en),
    .byte_done (byte_done)
  );

  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      n_reg     <= '0;
      addr_reg  <= '0;
      csum_reg  <= '0;
      data_reg  <= '0;
      go_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      addr_reg  <= addr_next;
      csum_reg  <= csum_next;
      data_reg  <= data_next;
      go_reg    <= go_next;
    end
  end

  // data_out only changes while the handshake is idle or draining, so it is
  // stable whenever trans_en is high. The checksum accumulates as each byte is
  // loaded into data_out.
  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    addr_next  = addr_reg;
    csum_next  = csum_reg;
    data_next  = data_reg;
    unique case (state_reg)
      IDLE: begin
        if (bus.start) begin
          n_next     = bus.byte_count;
          addr_next  = '0;
          csum_next  = '0;
          data_next  = HDR_BYTE;
          state_next = HDR;
        end
      end
      HDR: begin
        if (byte_done) begin
          data_next  = len16[15:8];
          csum_next  = csum_reg + len16[15:8];
          state_next = LEN_HI;
        end
      end
      LEN_HI: begin
        if (byte_done) begin
          data_next  = len16[7:0];
          csum_next  = csum_reg + len16[7:0];
          state_next = LEN_LO;
        end
      end
      LEN_LO: begin
        if (byte_done) begin
          if (n_reg == '0) begin
            data_next  = csum_reg;
            state_next = CSUM;
          end else begin
            state_next = RD;
          end
        end
      end
      RD: state_next = RDW;
      RDW: begin
        data_next  = bus.mem_rd_data;
        csum_next  = csum_reg + bus.mem_rd_data;
        state_next = PAY;
      end
      PAY: begin
        if (byte_done) begin
          addr_next = addr_inc[ADDR_W-1:0];
          if (more && !bus.abort) begin
            state_next = RD;
          end else begin
            data_next  = csum_reg;
            state_next = CSUM;
          end
        end
      end
      CSUM: begin
        if (byte_done) state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // One go pulse per byte state, issued the cycle after the state is entered.
    go_next = is_byte_state(state_next) && (state_next != state_reg);
  end

  assign bus.mem_rd_en = (state_reg == RD);
  assign bus.mem_addr  = addr_reg;
  assign bus.data_out  = data_reg;
  assign bus.trans_en  = hs_trans_en;
  assign bus.active    = (state_reg != IDLE) && (state_reg != FIN);
  assign bus.done      = (state_reg == FIN);

endmodule

// File: tb/tb_uart_dump_sequencer.sv
`timescale 1ns/1ps
module tb_uart_dump_sequencer;

  localparam int         ADDR_W     = 16;
  localparam int         START_HOLD = 12;
  localparam int         BAUD       = 8;
  localparam logic [7:0] HDR        = 8'hA5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_dump_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  uart_dump_sequencer #(
    .ADDR_W     (ADDR_W),
    .START_HOLD (START_HOLD),
    .HDR_BYTE   (HDR)
  ) dut (
    .input_clk (clk),
    .reset     (rst_n),
    .bus       (bus)
  );

  // Sample RAM: 1-cycle read latency.
  logic [7:0] ram [0:511];
  always_ff @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_addr[8:0]];
  end

  // Transmitter model: samples trans_en on baud ticks while idle, then stays busy
  // for 10 baud ticks. Each acceptance is one byte seen on the line.
  int         baud_cnt;
  int         tx_ticks;
  logic       rx_valid;
  logic [7:0] rx_byte;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt    <= 0;
      tx_ticks    <= 0;
      bus.tx_busy <= 1'b0;
      rx_valid    <= 1'b0;
      rx_byte     <= 8'h00;
    end else begin
      rx_valid <= 1'b0;
      if (baud_cnt == BAUD - 1) begin
        baud_cnt <= 0;
        if (!bus.tx_busy) begin
          if (bus.trans_en) begin
            bus.tx_busy <= 1'b1;
            tx_ticks    <= 0;
            rx_valid    <= 1'b1;
            rx_byte     <= bus.data_out;
          end
        end else if (tx_ticks == 9) begin
          bus.tx_busy <= 1'b0;
        end else begin
          tx_ticks <= tx_ticks + 1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1;
      end
    end
  end

  logic [7:0] exp_q [$];
  logic [7:0] exp_b;
  int   checks    = 0;
  int   errors    = 0;
  int   frame_rx  = 0;
  int   done_cnt  = 0;
  int   rd_cnt    = 0;
  int   hold_cnt  = 0;
  logic te_prev   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, req);
    end
  endtask

  // Reference frame: header, 16-bit length, the first k RAM bytes, 8-bit sum of
  // everything after the header.
  task automatic push_frame(input int n, input int abort_after, output int k);
    int sum;
    k = (abort_after > 0 && abort_after < n) ? abort_after : n;
    sum = ((n >> 8) & 255) + (n & 255);
    exp_q.push_back(HDR);
    exp_q.push_back(8'((n >> 8) & 255));
    exp_q.push_back(8'(n & 255));
    for (int i = 0; i < k; i++) begin
      exp_q.push_back(ram[i]);
      sum += int'(ram[i]);
    end
    exp_q.push_back(8'(sum % 256));
  endtask

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_cnt = 0;
        te_prev  = 1'b0;
      end else begin
        if (rx_valid) begin
          frame_rx++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL line_byte got %02h required none (extra or repeated byte)", rx_byte);
          end else begin
            exp_b = exp_q.pop_front();
            if (rx_byte !== exp_b) begin
              errors++;
              $display("FAIL line_byte #%0d got %02h required %02h", frame_rx, rx_byte, exp_b);
            end else begin
              $display("byte #%0d on line %02h as expected", frame_rx, rx_byte);
            end
          end
        end
        if (bus.trans_en && bus.tx_busy) hold_cnt++;
        if (te_prev && !bus.trans_en) begin
          checks++;
          if (hold_cnt < START_HOLD || hold_cnt > START_HOLD + 1) begin
            errors++;
            $display("FAIL trans_en_hold got %0d cycles required %0d..%0d", hold_cnt, START_HOLD, START_HOLD + 1);
          end
          hold_cnt = 0;
        end
        te_prev = bus.trans_en;
        if (bus.done) begin
          done_cnt++;
          check("active_with_done", 32'(bus.active), 32'd0);
        end
        if (bus.mem_rd_en) begin
          check("rd_addr", 32'(bus.mem_addr), 32'(rd_cnt));
          rd_cnt++;
        end
      end
    end
  end

  task automatic start_frame(input int n, input bit abort_with_start);
    frame_rx = 0;
    done_cnt = 0;
    rd_cnt   = 0;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.byte_count = 16'(n);
    bus.abort      = abort_with_start;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.byte_count = 16'($urandom);
  endtask

  task automatic run_frame(input int n, input int abort_after, input bit poke_start,
                           input bit abort_with_start);
    int k;
    int budget;
    bit ok;
    push_frame(n, abort_after, k);
    start_frame(n, abort_with_start);
    budget = (n + 6) * 150;
    ok = 1'b0;
    for (int cyc = 0; cyc < budget && !ok; cyc++) begin
      @(negedge clk);
      if (abort_after > 0 && frame_rx >= 3 + abort_after) bus.abort = 1'b1;
      if (poke_start && cyc == 60) begin
        bus.start      = 1'b1;
        bus.byte_count = 16'(n + 5);
      end else begin
        bus.start = 1'b0;
      end
      if (done_cnt > 0) ok = 1'b1;
    end
    bus.start = 1'b0;
    check("frame_done_seen", 32'(ok), 32'd1);
    repeat (30) @(negedge clk);
    bus.abort = 1'b0;
    check("bytes_missing", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check("done_count", 32'(done_cnt), 32'd1);
    check("active_after", 32'(bus.active), 32'd0);
    check("rd_count", 32'(rd_cnt), 32'(k));
  endtask

  initial begin
    int n;
    int k;
    int ab;
    bit reached;
    bus.start      = 1'b0;
    bus.byte_count = '0;
    bus.abort      = 1'b0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_trans_en", 32'(bus.trans_en), 32'd0);
    check("rst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("rst_active", 32'(bus.active), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three-byte frame: A5 00 03 11 22 33 69.
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33;
    run_frame(3, 0, 1'b0, 1'b0);

    // Empty frame: A5 00 00 00, no RAM reads (rd_count check).
    run_frame(0, 0, 1'b0, 1'b0);

    // 300-byte frame, RAM[i] = i.
    for (int i = 0; i < 512; i++) ram[i] = 8'(i);
    run_frame(300, 0, 1'b1, 1'b0);

    // Abort after the second payload byte of a five-byte frame.
    for (int i = 0; i < 512; i++) ram[i] = 8'($urandom);
    run_frame(5, 2, 1'b0, 1'b0);

    // Random frames; abort together with start in IDLE on the first one.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 64; i++) ram[i] = 8'($urandom);
      n  = int'($urandom_range(1, 24));
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n)) : 0;
      run_frame(n, ab, 1'(t & 1), (t == 0));
    end

    // Reset in the middle of the payload, then a fresh full frame.
    for (int i = 0; i < 64; i++) ram[i] = 8'($urandom);
    push_frame(10, 0, k);
    start_frame(10, 1'b0);
    reached = 1'b0;
    for (int cyc = 0; cyc < 3000 && !reached; cyc++) begin
      @(negedge clk);
      if (frame_rx >= 6) reached = 1'b1;
    end
    check("mid_payload_reached", 32'(reached), 32'd1);
    repeat (int'($urandom_range(1, 40))) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_trans_en", 32'(bus.trans_en), 32'd0);
    check("async_rst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("async_rst_active", 32'(bus.active), 32'd0);
    check("async_rst_done", 32'(bus.done), 32'd0);
    check("async_rst_data_out", 32'(bus.data_out), 32'd0);
    check("async_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 64; i++) ram[i] = 8'($urandom);
    run_frame(3, 0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout got no finish required finish");
    $fatal(1, "simulation time limit");
  end

endmodule
